// File: rtl/slot_sequencer_pkg.sv
// Shared constants and types for the channel slot sequencer and its host write buffer.
package slot_sequencer_pkg;

  localparam int NUM_CH             = 8;
  localparam int CH_W               = 3;
  localparam int SUB_CYCLES_DEFAULT = 16;
  localparam int CH_FIELD_HI        = 7;
  localparam int CH_FIELD_LO        = 5;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } host_wr_t;

  // Target channel carried in the upper address bits.
  function automatic logic [CH_W-1:0] addr_ch(input logic [7:0] addr);
    return addr[CH_FIELD_HI:CH_FIELD_LO];
  endfunction

endpackage

// File: rtl/slot_sequencer_host_wr_buffer.sv
// One-entry host write holding register; issues the held write at the end of a slot
// that does not belong to the write's own target channel.
module host_wr_buffer
  import slot_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            slot_end,
  input  logic [CH_W-1:0] ch,
  input  logic            wr_req,
  input  logic [7:0]      wr_addr,
  input  logic [7:0]      wr_data,
  output logic            busy,
  output logic            reg_we,
  output logic [7:0]      reg_addr,
  output logic [7:0]      reg_data
);

  host_wr_t   held_q, held_d;
  logic       busy_q, busy_d;
  logic       reg_we_q, reg_we_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_data_q, reg_data_d;

  always_comb begin
    held_d     = held_q;
    busy_d     = busy_q;
    reg_we_d   = 1'b0;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    if (!busy_q) begin
      if (wr_req) begin
        held_d = '{addr: wr_addr, data: wr_data};
        busy_d = 1'b1;
      end
    end else if (run && slot_end && (ch != addr_ch(held_q.addr))) begin
      // Never issue while the target channel's own select is still settling out.
      reg_we_d   = 1'b1;
      reg_addr_d = held_q.addr;
      reg_data_d = held_q.data;
      busy_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q     <= '0;
      busy_q     <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
    end else begin
      held_q     <= held_d;
      busy_q     <= busy_d;
      reg_we_q   <= reg_we_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
    end
  end

  assign busy     = busy_q;
  assign reg_we   = reg_we_q;
  assign reg_addr = reg_addr_q;
  assign reg_data = reg_data_q;

endmodule

// File: rtl/slot_sequencer.sv
// Eight-channel slot/phase sequencer with registered decoder controls and a
// buffered host register-write path.
module slot_sequencer
  import slot_sequencer_pkg::*;
#(
  parameter int SUB_CYCLES = SUB_CYCLES_DEFAULT,
  parameter int PW         = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            wr_req,
  input  logic [7:0]      wr_addr,
  input  logic [7:0]      wr_data,
  output logic [CH_W-1:0] ch,
  output logic            ch_en,
  output logic [PW-1:0]   phase,
  output logic            frame_end,
  output logic            busy,
  output logic            reg_we,
  output logic [7:0]      reg_addr,
  output logic [7:0]      reg_data
);

  localparam logic [PW-1:0]   PHASE_LAST = PW'(SUB_CYCLES - 1);
  localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0] ch_q, ch_d, ch_adv;
  logic [PW-1:0]   phase_q, phase_d, phase_adv;
  logic            ch_en_q, ch_en_d;
  logic            frame_end_q, frame_end_d;
  logic            slot_end;

  assign slot_end  = (phase_q == PHASE_LAST);
  assign phase_adv = slot_end ? '0 : phase_q + PW'(1);
  assign ch_adv    = slot_end ? ((ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1)) : ch_q;

  // Decoder controls are computed from the next state so they line up with ch/phase.
  always_comb begin
    ch_d        = ch_q;
    phase_d     = phase_q;
    ch_en_d     = 1'b0;
    frame_end_d = 1'b0;
    if (run) begin
      ch_d        = ch_adv;
      phase_d     = phase_adv;
      ch_en_d     = (phase_adv != '0);
      frame_end_d = (ch_adv == CH_LAST) && (phase_adv == PHASE_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q        <= '0;
      phase_q     <= '0;
      ch_en_q     <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      ch_q        <= ch_d;
      phase_q     <= phase_d;
      ch_en_q     <= ch_en_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign ch        = ch_q;
  assign phase     = phase_q;
  assign ch_en     = ch_en_q;
  assign frame_end = frame_end_q;

  host_wr_buffer u_host_wr_buffer (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .slot_end (slot_end),
    .ch       (ch_q),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .reg_we   (reg_we),
    .reg_addr (reg_addr),
    .reg_data (reg_data)
  );

endmodule

// File: tb/tb_slot_sequencer.sv
// Self-checking bench for slot_sequencer with SUB_CYCLES=4: counter model plus a
// scoreboard of expected register writes and their issue clocks.
module tb_slot_sequencer;

  localparam int SC    = 4;
  localparam int PW    = 6;
  localparam int FRAME = 8 * SC;

  logic       clk = 1'b0;
  logic       reset, run, wr_req;
  logic [7:0] wr_addr, wr_data;
  logic [2:0] ch;
  logic       ch_en, frame_end, busy, reg_we;
  logic [PW-1:0] phase;
  logic [7:0] reg_addr, reg_data;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cnt;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_cnt       = 0;
  int   last_issue  = -1;

  slot_sequencer #(.SUB_CYCLES(SC), .PW(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ch        (ch),
    .ch_en     (ch_en),
    .phase     (phase),
    .frame_end (frame_end),
    .busy      (busy),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_data  (reg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] m_ch(input int c);
    return 3'((c / SC) % 8);
  endfunction

  function automatic logic [PW-1:0] m_ph(input int c);
    return PW'(c % SC);
  endfunction

  // Issue clock for a write accepted at count c, with run held high.
  function automatic int issue_at(input int c, input logic [2:0] tch);
    for (int t = c + 1; t < c + 64; t++)
      if ((t % SC) == SC - 1 && m_ch(t) != tch) return t + 1;
    return -1;
  endfunction

  task automatic step();
    logic r;
    logic exp_en, exp_fe;
    exp_t e;
    r = run && !reset;
    if (reset) m_cnt = 0;
    else if (run) m_cnt++;
    @(posedge clk);
    #1;
    exp_en = r && (m_ph(m_cnt) != '0);
    exp_fe = r && ((m_cnt % FRAME) == FRAME - 1);
    vectors++;
    if (ch !== m_ch(m_cnt) || phase !== m_ph(m_cnt)) begin
      miscompares++;
      $display("FAIL counters: ch=%0d phase=%0d, expected ch=%0d phase=%0d", ch, phase, m_ch(m_cnt), m_ph(m_cnt));
    end
    vectors++;
    if (ch_en !== exp_en || frame_end !== exp_fe) begin
      miscompares++;
      $display("FAIL decode: ch_en=%b frame_end=%b, expected ch_en=%b frame_end=%b (cnt %0d)", ch_en, frame_end, exp_en, exp_fe, m_cnt);
    end
    if (reg_we === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_we: reg_we=1 addr=%02h data=%02h, expected no write", reg_addr, reg_data);
      end else begin
        e = sb_q.pop_front();
        last_issue = m_cnt;
        if (reg_addr !== e.addr || reg_data !== e.data || m_cnt != e.cnt) begin
          miscompares++;
          $display("FAIL write_issue: addr=%02h data=%02h cnt=%0d, expected addr=%02h data=%02h cnt=%0d",
                   reg_addr, reg_data, m_cnt, e.addr, e.data, e.cnt);
        end
      end
    end else if (sb_q.size() != 0 && m_cnt == sb_q[0].cnt) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_we: reg_we=%b at cnt %0d, expected 1", reg_we, m_cnt);
    end
  endtask

  task automatic goto(input int tgt);
    for (int i = 0; i < 2 * FRAME && (m_cnt % FRAME) != tgt; i++) step();
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] d, output int c);
    exp_t e;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    c = m_cnt;
    e.addr = a;
    e.data = d;
    e.cnt  = issue_at(c, a[7:5]);
    sb_q.push_back(e);
    step();
    wr_req = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_accept: busy=%b, expected 1", busy);
    end
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && sb_q.size() != 0; i++) step();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d writes pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    step();
    step();
    vectors++;
    if (ch !== 3'd0 || phase !== '0) begin
      miscompares++;
      $display("FAIL reset_cnt: ch=%0d phase=%0d, expected 0/0", ch, phase);
    end
    vectors++;
    if (ch_en !== 1'b0 || frame_end !== 1'b0 || busy !== 1'b0 || reg_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: ch_en=%b frame_end=%b busy=%b reg_we=%b, expected 0", ch_en, frame_end, busy, reg_we);
    end
    vectors++;
    if (reg_addr !== 8'h00 || reg_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_reg: addr=%02h data=%02h, expected 00/00", reg_addr, reg_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_frame();
    int fe_count = 0;
    int first_fe = -1;
    run = 1'b1;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      step();
      if (frame_end === 1'b1) begin
        fe_count++;
        if (first_fe < 0) first_fe = k;
      end
    end
    vectors++;
    if (fe_count != 2 || first_fe != 31) begin
      miscompares++;
      $display("FAIL frame_end_count: count=%0d first=%0d, expected 2 at 31", fe_count, first_fe);
    end
  endtask

  task automatic test_pause();
    goto(3 * SC + 2);
    run = 1'b0;
    repeat (5) step();
    vectors++;
    if (ch !== 3'd3 || phase !== PW'(2) || ch_en !== 1'b0) begin
      miscompares++;
      $display("FAIL pause_hold: ch=%0d phase=%0d ch_en=%b, expected 3/2/0", ch, phase, ch_en);
    end
    run = 1'b1;
    step();
    vectors++;
    if (ch !== 3'd3 || phase !== PW'(3)) begin
      miscompares++;
      $display("FAIL pause_resume: ch=%0d phase=%0d, expected 3/3", ch, phase);
    end
  endtask

  task automatic test_write_basic();
    int c;
    goto(1 * SC + 0);
    accept(8'h45, 8'hA5, c);
    drain(3 * SC);
    vectors++;
    if (last_issue - c != 4 || ch !== 3'd2 || phase !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL write_basic: lat=%0d ch=%0d phase=%0d busy=%b, expected 4/2/0/0", last_issue - c, ch, phase, busy);
    end
    step();
    vectors++;
    if (reg_we !== 1'b0 || reg_addr !== 8'h45 || reg_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL write_hold: we=%b addr=%02h data=%02h, expected 0/45/A5", reg_we, reg_addr, reg_data);
    end
  endtask

  task automatic test_write_skip();
    int c;
    goto(2 * SC + 3);
    accept(8'h60, 8'h3C, c);
    drain(3 * SC);
    vectors++;
    if (last_issue - c != 2 * SC + 1 || ch !== 3'd5 || phase !== '0) begin
      miscompares++;
      $display("FAIL write_skip: lat=%0d ch=%0d phase=%0d, expected 9/5/0", last_issue - c, ch, phase);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    goto(2 * SC + 0);
    accept(8'h20, 8'h5C, c);
    wr_req  = 1'b1;
    wr_addr = 8'h80;
    wr_data = 8'h11;
    step();
    wr_req = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_hold: busy=%b, expected 1", busy);
    end
    drain(3 * SC);
    vectors++;
    if (reg_data !== 8'h5C) begin
      miscompares++;
      $display("FAIL first_data: data=%02h, expected 5C", reg_data);
    end
    repeat (2 * SC + 2) step();
  endtask

  task automatic test_reset_discard();
    int c;
    goto(4 * SC + 0);
    accept(8'h40, 8'h77, c);
    reset = 1'b1;
    sb_q.delete();
    step();
    vectors++;
    if (busy !== 1'b0 || reg_we !== 1'b0 || reg_addr !== 8'h00 || reg_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_discard: busy=%b we=%b addr=%02h data=%02h, expected 0/0/00/00", busy, reg_we, reg_addr, reg_data);
    end
    reset = 1'b0;
    repeat (40) step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy_after: busy=%b, expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_pause();
    test_write_basic();
    test_write_skip();
    test_back_to_back();
    test_reset_discard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slot_sequencer.md
SLOT_SEQUENCER -- requirements
Module: slot_sequencer

Interface
REQ-001 Parameter SUB_CYCLES, default 16; clocks per channel slot; legal values 4..64, power of two.
REQ-002 Parameter PW, default 6; phase counter width; SHALL hold SUB_CYCLES-1.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 run  in  1  sequencer enable; low freezes slot and phase counters.
REQ-006 wr_req  in  1  host register-write request; sampled only while busy is low.
REQ-007 wr_addr  in  8  host register address; bits [7:5] are the target channel.
REQ-008 wr_data  in  8  host write data.
REQ-009 ch  out  3  current channel slot index; drives the 3-to-8 select decoder input.
REQ-010 ch_en  out  1  decoder enable; high while the slot's select is valid.
REQ-011 phase  out  PW  position within the current slot.
REQ-012 frame_end  out  1  one-cycle pulse on the last clock of channel 7's slot.
REQ-013 busy  out  1  a host write is held and not yet issued.
REQ-014 reg_we  out  1  one-cycle register write strobe.
REQ-015 reg_addr  out  8  address qualified by reg_we.
REQ-016 reg_data  out  8  data qualified by reg_we.

Function
REQ-017 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-018 While run is high, phase SHALL increment by 1 each clock and wrap from SUB_CYCLES-1 to 0.
REQ-019 On each phase wrap, ch SHALL increment by 1, wrapping from 7 to 0.
REQ-020 One frame SHALL be exactly 8*SUB_CYCLES clocks.
REQ-021 While run is low, ch and phase SHALL hold, ch_en SHALL be 0 and frame_end SHALL be 0.
REQ-022 ch_en SHALL be 1 only when running and phase != 0; phase 0 is the address-settle clock.
REQ-023 frame_end SHALL be 1 only for the clock where ch=7, phase=SUB_CYCLES-1 and run=1.
REQ-024 When run deasserts mid-slot, the sequencer SHALL resume from the held ch/phase once run reasserts.
REQ-025 Host write, accept: when wr_req=1 and busy=0, the sequencer SHALL latch wr_addr and wr_data, and busy SHALL be 1 on the next clock.
REQ-026 Host write, busy: wr_req while busy=1 SHALL be ignored, and the held address and data SHALL not change.
REQ-027 Host write, qualifying clock: a clock with busy=1, run=1, phase=SUB_CYCLES-1 and ch != held address bits [7:5].
REQ-028 Host write, issue: in the clock after a qualifying clock, reg_we SHALL be 1 for exactly one clock, reg_addr/reg_data SHALL equal the held values, and busy SHALL be 0.
REQ-029 A write SHALL never issue at the end of its own target channel's slot; it waits for the next slot.
REQ-030 Worst-case issue latency SHALL be 2*SUB_CYCLES+1 clocks from acceptance with run held high.
REQ-031 wr_req in the same clock that busy falls SHALL be ignored, because busy is sampled as registered.
REQ-032 reg_addr and reg_data SHALL hold their last issued values while reg_we=0.

Reset
REQ-033 Reset SHALL set ch=0, phase=0, ch_en=0, frame_end=0, busy=0, reg_we=0, reg_addr=0 and reg_data=0.
REQ-034 Reset SHALL discard any held host write without issuing it.
REQ-035 Reset SHALL take priority over run and wr_req in the same clock.

Structure
REQ-036 The shared package SHALL hold NUM_CH=8, the default SUB_CYCLES and the channel-field bit positions of the address (7:5).
REQ-037 The design SHALL have one sub-module, host_wr_buffer, containing the one-entry holding register, busy and the issue logic.
REQ-038 The slot/phase counters SHALL remain in the top level.

Verification (SUB_CYCLES=4)
REQ-039 Reset, then run=1 for 64 clocks -> ch sequence 0..7, two full frames; frame_end high at clocks 31 and 63; ch_en low at phase 0 only.
REQ-040 run low at ch=3, phase=2 for 5 clocks -> ch/phase held at 3/2, ch_en=0; after run returns high, the next clock shows phase 3.
REQ-041 wr_req with addr=0x45, data=0xA5 accepted at ch=1, phase=0 -> busy next clock; reg_we at ch=2, phase 0; reg_addr=0x45, reg_data=0xA5.
REQ-042 wr_req with addr=0x60 (channel 3) accepted at ch=2, phase=3 -> the ch=3 slot end is skipped; reg_we at ch=5, phase 0 after ch=4's last clock; worst-case 9-clock bound met.
REQ-043 Second wr_req with data=0x11 while busy -> the first write's data is issued; 0x11 never appears on reg_data.
REQ-044 Reset asserted with busy=1 -> busy=0 and no reg_we in the following 40 clocks with wr_req=0.
